// File: rtl/sb_pkg.sv
// Shared constants, entry layout and parameter checks for the write-combining store buffer.
package sb_pkg;

  localparam int SB_AW    = 15;
  localparam int SB_DW    = 16;
  localparam int SB_DEPTH = 4;
  localparam int SB_NRD   = 2;

  typedef struct packed {
    logic              valid;
    logic [SB_AW-1:0]  addr;
    logic [SB_DW-1:0]  data;
  } sb_entry_t;

  function automatic bit sb_depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/sb_match.sv
// One address lookup over the buffer: store bypass first, then the younger non-head copy, then the head.
module sb_match
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]         valid,
  input  logic [DEPTH-1:0][AW-1:0] addr,
  input  logic [DEPTH-1:0][DW-1:0] data,
  input  logic [PW-1:0]            head,
  input  logic [AW-1:0]            raddr,
  input  logic                     byp_en,
  input  logic [AW-1:0]            byp_addr,
  input  logic [DW-1:0]            byp_data,
  output logic                     hit,
  output logic [DW-1:0]            rdata,
  output logic                     nh_hit,
  output logic [PW-1:0]            nh_idx
);

  logic [DW-1:0] nh_data;
  logic          hd_hit;

  // At most one non-head entry can hold a given address, so the scan never has to arbitrate.
  always_comb begin
    nh_hit  = 1'b0;
    nh_idx  = '0;
    nh_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (addr[i] == raddr) && (PW'(i) != head)) begin
        nh_hit  = 1'b1;
        nh_idx  = PW'(i);
        nh_data = data[i];
      end
    end
  end

  assign hd_hit = valid[head] && (addr[head] == raddr);

  always_comb begin
    hit   = 1'b0;
    rdata = '0;
    if (byp_en && (byp_addr == raddr)) begin
      hit   = 1'b1;
      rdata = byp_data;
    end else if (nh_hit) begin
      hit   = 1'b1;
      rdata = nh_data;
    end else if (hd_hit) begin
      hit   = 1'b1;
      rdata = data[head];
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Write-combining store FIFO: merges repeat stores, forwards to loads, drains the head to memory.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW,
  parameter int NRD   = SB_NRD
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wen,
  input  logic [AW-1:0]              waddr,
  input  logic [DW-1:0]              wdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic [NRD*AW-1:0]          raddr,
  output logic [NRD-1:0]             rexists,
  output logic [NRD*DW-1:0]          rdata,
  output logic                       mem_wen,
  output logic [AW-1:0]              mem_waddr,
  output logic [DW-1:0]              mem_wdata,
  input  logic                       mem_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  if (!sb_depth_ok(DEPTH)) begin : g_bad_depth
    $error("store_buffer: DEPTH must be a power of two and at least 2");
  end

  logic [DEPTH-1:0]         valid_q;
  logic [DEPTH-1:0][AW-1:0] addr_q;
  logic [DEPTH-1:0][DW-1:0] data_q;
  logic [PW-1:0]            head_q;
  logic [PW-1:0]            tail_q;
  logic [CW-1:0]            count_q;

  logic          merge_hit;
  logic [PW-1:0] merge_idx;
  logic          merge;
  logic          alloc;
  logic          accept;
  logic          drain;
  logic          merge_unused_hit;
  logic [DW-1:0] merge_unused_data;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign mem_wen = ~empty;
  // Zero when idle so a stale, already-drained head never shows on the memory bus.
  assign mem_waddr = mem_wen ? addr_q[head_q] : '0;
  assign mem_wdata = mem_wen ? data_q[head_q] : '0;

  assign drain  = mem_wen & mem_ready;
  assign merge  = wen & merge_hit;
  assign alloc  = wen & ~merge_hit & ~full;
  assign accept = merge | alloc;

  // Merge probe ignores the head so the entry on the memory bus stays frozen.
  sb_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .PW(PW)) u_merge (
    .valid    (valid_q),
    .addr     (addr_q),
    .data     (data_q),
    .head     (head_q),
    .raddr    (waddr),
    .byp_en   (1'b0),
    .byp_addr (waddr),
    .byp_data (wdata),
    .hit      (merge_unused_hit),
    .rdata    (merge_unused_data),
    .nh_hit   (merge_hit),
    .nh_idx   (merge_idx)
  );

  logic [NRD-1:0]         port_unused_nh_hit;
  logic [NRD-1:0][PW-1:0] port_unused_nh_idx;

  for (genvar g = 0; g < NRD; g++) begin : g_port
    sb_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .PW(PW)) u_match (
      .valid    (valid_q),
      .addr     (addr_q),
      .data     (data_q),
      .head     (head_q),
      .raddr    (raddr[g*AW +: AW]),
      .byp_en   (wen & accept),
      .byp_addr (waddr),
      .byp_data (wdata),
      .hit      (rexists[g]),
      .rdata    (rdata[g*DW +: DW]),
      .nh_hit   (port_unused_nh_hit[g]),
      .nh_idx   (port_unused_nh_idx[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      if (merge) begin
        data_q[merge_idx] <= wdata;
      end
      // Allocation only lands on the head slot when the buffer is empty, so it never races the drain.
      if (alloc) begin
        valid_q[tail_q] <= 1'b1;
        addr_q[tail_q]  <= waddr;
        data_q[tail_q]  <= wdata;
        tail_q          <= tail_q + PW'(1);
      end
      case ({alloc, drain})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
